// File: rtl/state_table_arbiter.sv
// 16-entry {action,state} table shared by pipeline lookup, pipeline writeback
// and control-plane config ports, with a starvation guard for config.
module state_table_arbiter #(
    parameter int          STARVE_LIMIT = 8,
    parameter logic [23:0] ENTRY0_INIT  = 24'hFFFF01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lk_req,
    input  logic [3:0]  lk_idx,
    output logic        lk_gnt,
    output logic        lk_rsp_vld,
    output logic [15:0] lk_action,
    output logic [7:0]  lk_state,
    input  logic        up_req,
    input  logic [3:0]  up_idx,
    input  logic [23:0] up_data,
    output logic        up_gnt,
    input  logic        cfg_req,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_idx,
    input  logic [23:0] cfg_wdata,
    output logic        cfg_ack,
    output logic [23:0] cfg_rdata,
    output logic        init_done
);
    // state  | meaning
    // S_INIT | sweeping entries 0..15 to their reset contents, no grants
    // S_RUN  | arbitrating update > lookup > config, config forced when starved
    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam int SW = ($clog2(STARVE_LIMIT + 1) > 4) ? $clog2(STARVE_LIMIT + 1) : 4;
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    state_t        state;
    logic [3:0]    init_idx;
    logic [23:0]   table_mem [16];
    logic [SW-1:0] starve_cnt;
    logic          cfg_ack_r;
    logic          lk_rsp_r;
    logic          running;
    logic          cfg_avail;
    logic          force_cfg;
    logic          cfg_gnt;

    // A config access already in flight must not be granted again while the
    // requester is still holding cfg_req during its ack cycle.
    assign running   = (state == S_RUN) && !reset;
    assign cfg_avail = cfg_req && !cfg_ack_r;
    assign force_cfg = cfg_avail && (starve_cnt == LIMIT);

    assign up_gnt  = running && up_req && !force_cfg;
    assign lk_gnt  = running && lk_req && !up_req && !force_cfg;
    assign cfg_gnt = running && cfg_avail && (force_cfg || (!up_req && !lk_req));

    assign cfg_ack    = cfg_ack_r && !reset;
    assign lk_rsp_vld = lk_rsp_r && !reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_INIT)
                table_mem[init_idx] <= (init_idx == 4'd0) ? ENTRY0_INIT : 24'h0;
            else if (up_gnt)
                table_mem[up_idx] <= up_data;
            else if (cfg_gnt && cfg_we)
                table_mem[cfg_idx] <= cfg_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_INIT;
            init_idx   <= 4'd0;
            init_done  <= 1'b0;
            starve_cnt <= '0;
            cfg_ack_r  <= 1'b0;
            lk_rsp_r   <= 1'b0;
            lk_action  <= 16'h0;
            lk_state   <= 8'h0;
            cfg_rdata  <= 24'h0;
        end else begin
            case (state)
                S_INIT: begin
                    init_idx <= init_idx + 4'd1;
                    if (init_idx == 4'd15) begin
                        state     <= S_RUN;
                        init_done <= 1'b1;
                    end
                end
                S_RUN: begin
                    state <= S_RUN;
                end
                default: state <= S_INIT;
            endcase

            lk_rsp_r  <= lk_gnt;
            cfg_ack_r <= cfg_gnt;

            if (lk_gnt) begin
                lk_action <= table_mem[lk_idx][23:8];
                lk_state  <= table_mem[lk_idx][7:0];
            end

            if (cfg_gnt && !cfg_we)
                cfg_rdata <= table_mem[cfg_idx];

            if (cfg_ack_r)
                starve_cnt <= '0;
            else if (running && cfg_req && !cfg_gnt && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + SW'(1);
        end
    end
endmodule
